lr_car_detector: RTL

- Front-end vehicle detector for the local-road approach. Produces the `lr_has_car` request consumed by the traffic light controller, and observes that controller's `lr_light` output to know when waiting cars are served.
- Synchronises and debounces a raw inductive-loop sensor and counts confirmed arrivals.
- Holds the request until the local road receives green.

---
 rtl/lr_car_detector.sv | 125 ++++++++++++
 1 files changed

// File: rtl/lr_car_detector.sv
// rtl/lr_car_detector.sv - loop-sensor debounce, arrival counter and local-road request
// Optional stuck-sensor detection: define LR_STUCK_SENSOR_EN.
module lr_car_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int STUCK_CYCLES    = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_raw,
    input  logic [2:0]       lr_light,
    output logic             lr_has_car,
    output logic             car_pulse,
    output logic [CNT_W-1:0] car_count,
    output logic             sensor_fault
);

    typedef enum logic [1:0] {IDLE, RISE, PRESENT, FALL} state_t;

    localparam logic [3:0]       DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_nxt;
    logic [3:0] db_cnt, db_nxt;
    logic       s_meta, s_sync;
    logic       confirm;
    logic       green;

    assign green = (lr_light == 3'b100);

    always_ff @(posedge clk) begin
        if (rst) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
        end else begin
            s_meta <= sensor_raw;
            s_sync <= s_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            db_cnt    <= '0;
            car_pulse <= 1'b0;
            car_count <= '0;
        end else begin
            state     <= state_nxt;
            db_cnt    <= db_nxt;
            car_pulse <= confirm;
            if (green)
                car_count <= '0;
            else if (confirm && car_count != CNT_MAX)
                car_count <= car_count + 1'b1;
        end
    end

    // FALL returning to PRESENT deliberately skips the pulse: a flickering loop is one car.
    always_comb begin
        state_nxt = state;
        db_nxt    = db_cnt;
        confirm   = 1'b0;
        case (state)
            IDLE: if (s_sync) begin
                state_nxt = RISE;
                db_nxt    = '0;
            end
            RISE: begin
                if (!s_sync)
                    state_nxt = IDLE;
                else if (db_cnt == DB_LAST) begin
                    state_nxt = PRESENT;
                    confirm   = 1'b1;
                end else
                    db_nxt = db_cnt + 4'd1;
            end
            PRESENT: if (!s_sync) begin
                state_nxt = FALL;
                db_nxt    = '0;
            end
            FALL: begin
                if (s_sync)
                    state_nxt = PRESENT;
                else if (db_cnt == DB_LAST)
                    state_nxt = IDLE;
                else
                    db_nxt = db_cnt + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef LR_STUCK_SENSOR_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);

    logic [SW-1:0] stuck_cnt;
    logic          fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_cnt <= '0;
            fault_q   <= 1'b0;
        end else if (green || !(state == PRESENT || state == FALL)) begin
            stuck_cnt <= '0;
        end else if (!fault_q) begin
            if (stuck_cnt == SW'(STUCK_CYCLES - 1))
                fault_q <= 1'b1;
            else
                stuck_cnt <= stuck_cnt + 1'b1;
        end
    end
`endif

    // A stuck loop forces the request so the local road is never starved.
    always_comb begin
`ifdef LR_STUCK_SENSOR_EN
        sensor_fault = fault_q;
        lr_has_car   = (car_count != '0) || fault_q;
`else
        sensor_fault = 1'b0;
        lr_has_car   = (car_count != '0);
`endif
    end

endmodule
